// File: rtl/nbit_seq_shifter_if.sv
// -----------------------------------------------------------------------------
// nbit_seq_shifter_if
//
// Purpose: groups the request and result signals of nbit_seq_shifter so the
// shifter and its user connect through one bundle.
//
// Signals:
//   start      request to begin an operation, sampled on the rising clock edge
//   in         operand, captured when start is accepted
//   amt        shift amount 0..n-1, captured when start is accepted
//   mode       shift mode, captured when start is accepted
//                00 logical left, 01 logical right,
//                10 arithmetic right, 11 rotate left
//   out        working register, straight from the flop
//   busy       high while shifting is in progress
//   done       one-cycle completion pulse; out holds the final result
//   state_dbg  current FSM state, for observation only
//
// Modports:
//   master  drives the request side, observes the results
//   slave   the shifter itself
// -----------------------------------------------------------------------------
interface nbit_seq_shifter_if #(
   parameter int n = 8
);
   localparam int aw = $clog2(n);

   logic          start;
   logic [n-1:0]  in;
   logic [aw-1:0] amt;
   logic [1:0]    mode;
   logic [n-1:0]  out;
   logic          busy;
   logic          done;
   logic [1:0]    state_dbg;

   modport master (
      output start, in, amt, mode,
      input  out, busy, done, state_dbg
   );

   modport slave (
      input  start, in, amt, mode,
      output out, busy, done, state_dbg
   );
endinterface

// File: rtl/nbit_seq_shifter.sv
// -----------------------------------------------------------------------------
// nbit_seq_shifter
//
// Purpose: low-area sequential shifter. An n-bit operand is loaded on an
// accepted start and shifted one position per clock (logical left, logical
// right, arithmetic right or rotate left) until the requested amount has been
// applied, then a one-cycle done pulse is raised.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  nbit_seq_shifter_if slave modport (start/in/amt/mode in,
//        out/busy/done/state_dbg out)
//
// Handshake: start is a request qualified by the shifter being able to take
// it. It is accepted on any rising edge where the state is IDLE or DONE
// (i.e. busy is low); while busy is high start is ignored and the captured
// operands are never disturbed. Each accepted start produces exactly one done
// pulse unless reset intervenes. Holding start high through DONE reloads on
// that same edge, giving back-to-back operation.
// -----------------------------------------------------------------------------
module nbit_seq_shifter #(
   parameter int n = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   nbit_seq_shifter_if.slave    bus
);
   localparam int aw = $clog2(n);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        state, state_nx;
   logic [n-1:0]  wr, wr_nx;
   logic [aw-1:0] cnt, cnt_nx;
   logic [1:0]    mode_q, mode_nx;
   logic [n-1:0]  wr_sh;

   // One-position shift of the working register under the latched mode.
   always_comb begin
      wr_sh = wr;
      case (mode_q)
         2'b00:   wr_sh = {wr[n-2:0], 1'b0};
         2'b01:   wr_sh = {1'b0, wr[n-1:1]};
         2'b10:   wr_sh = {wr[n-1], wr[n-1:1]};
         2'b11:   wr_sh = {wr[n-2:0], wr[n-1]};
         default: wr_sh = wr;
      endcase
   end

   // Next-state and datapath update.
   always_comb begin
      state_nx = state;
      wr_nx    = wr;
      cnt_nx   = cnt;
      mode_nx  = mode_q;
      case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               wr_nx    = bus.in;
               cnt_nx   = bus.amt;
               mode_nx  = bus.mode;
               // A zero amount skips SHIFT entirely; the operand is the result.
               state_nx = (bus.amt != '0) ? SHIFT : DONE;
            end else if (state == DONE) begin
               state_nx = IDLE;
            end
         end
         SHIFT: begin
            wr_nx  = wr_sh;
            cnt_nx = cnt - 1'b1;
            // cnt==1 means this edge applies the last shift.
            if (cnt == aw'(1)) begin
               state_nx = DONE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         wr     <= '0;
         cnt    <= '0;
         mode_q <= 2'b00;
      end else begin
         state  <= state_nx;
         wr     <= wr_nx;
         cnt    <= cnt_nx;
         mode_q <= mode_nx;
      end
   end

   // All outputs decode directly from flops; no input reaches an output
   // combinationally.
   assign bus.out       = wr;
   assign bus.busy      = (state == SHIFT);
   assign bus.done      = (state == DONE);
   assign bus.state_dbg = state;

endmodule
